// File: rtl/snake_matrix_renderer.sv
// Frame renderer and row-scan driver for the snake LED matrix.
// Rasterises body segments and apple into a back buffer, then swaps atomically to the display.
module snake_matrix_renderer #(
    parameter int COLS    = 6,
    parameter int ROWS    = 6,
    parameter int XW      = 3,
    parameter int YW      = 3,
    parameter int MAX_LEN = 16,
    parameter int LW      = 5
) (
    input  logic                 clock,
    input  logic                 restart_n,
    input  logic                 render_start,
    input  logic [LW-1:0]        snake_size,
    output logic [LW-1:0]        seg_addr,
    input  logic [XW-1:0]        seg_x,
    input  logic [YW-1:0]        seg_y,
    input  logic [XW-1:0]        apple_x,
    input  logic [YW-1:0]        apple_y,
    input  logic                 apple_en,
    input  logic                 blink_en,
    input  logic                 blink_tick,
    input  logic                 scan_tick,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 coord_err,
    output logic [ROWS*COLS-1:0] leds,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_data
);
    localparam int NPIX = ROWS * COLS;
    localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_DRAIN, S_APPLE, S_SWAP} state_t;

    state_t          r_state, w_next;
    logic [LW-1:0]   r_n, r_addr;
    logic [NPIX-1:0] r_back, r_front;
    logic            r_err, r_done, r_phase;
    logic [RW-1:0]   r_row;
    logic [XW-1:0]   r_ab_x, r_af_x;
    logic [YW-1:0]   r_ab_y, r_af_y;
    logic            r_ab_v, r_af_v;

    logic            w_seg_ok, w_apl_ok, w_cap;
    logic [IW-1:0]   w_seg_idx, w_apl_idx;
    logic [NPIX-1:0] w_apl_mask, w_leds, w_shift;

    assign w_seg_ok  = ({1'b0, seg_x} < (XW+1)'(COLS)) && ({1'b0, seg_y} < (YW+1)'(ROWS));
    assign w_apl_ok  = ({1'b0, apple_x} < (XW+1)'(COLS)) && ({1'b0, apple_y} < (YW+1)'(ROWS));
    assign w_seg_idx = IW'(seg_y) * IW'(COLS) + IW'(seg_x);
    assign w_apl_idx = IW'(r_af_y) * IW'(COLS) + IW'(r_af_x);
    // Read data for address 0 is not valid until the second FETCH edge.
    assign w_cap     = ((r_state == S_FETCH) && (r_addr != '0)) || (r_state == S_DRAIN);

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (render_start) w_next = S_CLEAR;
            S_CLEAR: w_next = (r_n != '0) ? S_FETCH : S_APPLE;
            S_FETCH: if (r_addr + LW'(1) == r_n) w_next = S_DRAIN;
            S_DRAIN: w_next = S_APPLE;
            S_APPLE: w_next = S_SWAP;
            S_SWAP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            r_n     <= '0;
            r_addr  <= '0;
            r_back  <= '0;
            r_front <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_phase <= 1'b1;
            r_row   <= '0;
            r_ab_x  <= '0;
            r_ab_y  <= '0;
            r_ab_v  <= 1'b0;
            r_af_x  <= '0;
            r_af_y  <= '0;
            r_af_v  <= 1'b0;
        end else begin
            r_done <= (r_state == S_SWAP);
            if (blink_tick) r_phase <= ~r_phase;
            if (scan_tick)  r_row   <= (r_row == RW'(ROWS-1)) ? '0 : r_row + RW'(1);

            case (r_state)
                S_IDLE: if (render_start)
                    r_n <= (snake_size > LW'(MAX_LEN)) ? LW'(MAX_LEN) : snake_size;
                S_CLEAR: begin
                    r_back <= '0;
                    r_addr <= '0;
                end
                S_FETCH: r_addr <= r_addr + LW'(1);
                // Apple goes to a staging copy so the display only moves at the swap.
                S_APPLE: begin
                    r_ab_x <= apple_x;
                    r_ab_y <= apple_y;
                    r_ab_v <= apple_en & w_apl_ok;
                    if (apple_en && !w_apl_ok) r_err <= 1'b1;
                end
                S_SWAP: begin
                    r_front <= r_back;
                    r_af_x  <= r_ab_x;
                    r_af_y  <= r_ab_y;
                    r_af_v  <= r_ab_v;
                end
                default: ;
            endcase

            if (w_cap) begin
                if (w_seg_ok) r_back <= r_back | (NPIX'(1) << w_seg_idx);
                else          r_err  <= 1'b1;
            end
        end
    end

    assign w_apl_mask = (r_af_v && (!blink_en || r_phase)) ? (NPIX'(1) << w_apl_idx) : '0;
    assign w_leds     = r_front | w_apl_mask;
    assign w_shift    = w_leds >> (r_row * COLS);

    assign leds       = w_leds;
    assign col_data   = w_shift[COLS-1:0];
    assign row_sel    = ROWS'(1) << r_row;
    assign seg_addr   = r_addr;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_done;
    assign coord_err  = r_err;
endmodule

// File: tb/tb_snake_matrix_renderer.sv
// Directed bench for snake_matrix_renderer: render timing, clamp, coord errors, blink, scan, reset.
module tb_snake_matrix_renderer;
    logic        clock = 1'b0;
    logic        restart_n = 1'b0;
    logic        render_start = 1'b0;
    logic [4:0]  snake_size = '0;
    logic [4:0]  seg_addr;
    logic [2:0]  seg_x = '0, seg_y = '0;
    logic [2:0]  apple_x = '0, apple_y = '0;
    logic        apple_en = 1'b0, blink_en = 1'b0, blink_tick = 1'b0, scan_tick = 1'b0;
    logic        busy, frame_done, coord_err;
    logic [35:0] leds;
    logic [5:0]  row_sel, col_data;

    logic [2:0]  mem_x [0:31];
    logic [2:0]  mem_y [0:31];
    int          n_chk = 0, n_err = 0;

    localparam logic [35:0] BASIC = (36'd1 << 14) | (36'd1 << 15) | (36'd1 << 16);

    snake_matrix_renderer dut (
        .clock(clock), .restart_n(restart_n), .render_start(render_start),
        .snake_size(snake_size), .seg_addr(seg_addr), .seg_x(seg_x), .seg_y(seg_y),
        .apple_x(apple_x), .apple_y(apple_y), .apple_en(apple_en), .blink_en(blink_en),
        .blink_tick(blink_tick), .scan_tick(scan_tick), .busy(busy), .frame_done(frame_done),
        .coord_err(coord_err), .leds(leds), .row_sel(row_sel), .col_data(col_data)
    );

    always #5 clock = ~clock;

    // Synchronous-read body memory: data one cycle after the address.
    always @(posedge clock) begin
        seg_x <= mem_x[seg_addr];
        seg_y <= mem_y[seg_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_basic();
        for (int i = 0; i < 32; i++) begin mem_x[i] = 3'd0; mem_y[i] = 3'd0; end
        mem_x[0] = 3'd2; mem_y[0] = 3'd2;
        mem_x[1] = 3'd3; mem_y[1] = 3'd2;
        mem_x[2] = 3'd4; mem_y[2] = 3'd2;
    endtask

    // Pulses render_start, checks busy/hold each cycle until frame_done, then the latency and result.
    task automatic render(input string tag, input int exp_lat, input logic [35:0] prev,
                          input logic [35:0] exp, input bit dbl);
        int lat;
        int extra;
        @(negedge clock); render_start = 1'b1;
        @(negedge clock); render_start = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            if (frame_done) lat = i;
            else begin
                chk({tag, "_busy"}, busy, 1);
                chk({tag, "_hold"}, leds, prev);
                if (dbl && i == 2) render_start = 1'b1;
                if (dbl && i == 3) render_start = 1'b0;
                @(negedge clock);
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_leds"}, leds, exp);
        chk({tag, "_idle"}, busy, 0);
        extra = 0;
        for (int i = 0; i < (dbl ? 25 : 1); i++) begin
            @(negedge clock);
            if (frame_done) extra++;
        end
        chk({tag, "_pulse"}, extra, 0);
    endtask

    task automatic blink_pulse();
        @(negedge clock); blink_tick = 1'b1;
        @(negedge clock); blink_tick = 1'b0;
    endtask

    initial begin
        logic [35:0] e;
        int          seen;
        load_basic();
        // Reset and idle
        repeat (3) @(negedge clock);
        chk("rst_leds", leds, 0);
        chk("rst_row", row_sel, 6'b000001);
        chk("rst_busy", busy, 0);
        chk("rst_err", coord_err, 0);
        chk("rst_addr", seg_addr, 0);
        chk("rst_col", col_data, 0);
        restart_n = 1'b1;
        seen = 0;
        repeat (6) begin @(negedge clock); if (frame_done) seen++; end
        chk("idle_nodone", seen, 0);

        // Basic render
        snake_size = 5'd3; apple_x = 3'd0; apple_y = 3'd5; apple_en = 1'b1;
        render("basic", 7, 36'd0, BASIC | (36'd1 << 30), 1'b0);
        chk("basic_err", coord_err, 0);

        // Empty body
        snake_size = 5'd0; apple_x = 3'd1; apple_y = 3'd0;
        render("n0", 3, BASIC | (36'd1 << 30), 36'd2, 1'b0);

        // Out-of-range segment and length clamp
        for (int i = 0; i < 16; i++) begin mem_x[i] = 3'd1; mem_y[i] = 3'd1; end
        mem_x[5] = 3'd6; mem_y[5] = 3'd0;
        for (int i = 16; i < 20; i++) begin mem_x[i] = 3'd5; mem_y[i] = 3'd0; end
        snake_size = 5'd20; apple_en = 1'b0;
        render("clamp", 20, 36'd2, 36'd1 << 7, 1'b0);
        chk("clamp_addr", seg_addr, 16);
        chk("clamp_err", coord_err, 1);

        load_basic();
        snake_size = 5'd3; apple_x = 3'd0; apple_y = 3'd5; apple_en = 1'b1;
        render("clean", 7, 36'd1 << 7, BASIC | (36'd1 << 30), 1'b0);
        chk("err_sticky", coord_err, 1);

        // Scan wrap
        e = BASIC | (36'd1 << 30);
        for (int r = 0; r < 6; r++) begin
            chk("scan_row", row_sel, 6'd1 << r);
            chk("scan_col", col_data, (e >> (r * 6)) & 36'h3f);
            @(negedge clock); scan_tick = 1'b1;
            @(negedge clock); scan_tick = 1'b0;
        end
        chk("scan_wrap", row_sel, 6'b000001);

        // Blink, apple off-body then on-body
        blink_en = 1'b1; apple_x = 3'd5; apple_y = 3'd5;
        render("blink", 7, BASIC | (36'd1 << 30), BASIC | (36'd1 << 35), 1'b0);
        blink_pulse();
        chk("blink_off", leds, BASIC);
        blink_pulse();
        chk("blink_on", leds, BASIC | (36'd1 << 35));
        apple_x = 3'd2; apple_y = 3'd2;
        render("overlap", 7, BASIC | (36'd1 << 35), BASIC, 1'b0);
        for (int k = 0; k < 2; k++) begin
            blink_pulse();
            chk("overlap_b14", leds[14], 1);
            chk("overlap_leds", leds, BASIC);
        end

        // Render request while busy is dropped
        blink_en = 1'b0; apple_x = 3'd0; apple_y = 3'd5;
        render("dbl", 7, BASIC, BASIC | (36'd1 << 30), 1'b1);

        // Reset during FETCH
        @(negedge clock); render_start = 1'b1;
        @(negedge clock); render_start = 1'b0;
        @(negedge clock);
        restart_n = 1'b0;
        #1;
        chk("mrst_leds", leds, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_err", coord_err, 0);
        chk("mrst_addr", seg_addr, 0);
        @(negedge clock); restart_n = 1'b1;
        render("post", 7, 36'd0, BASIC | (36'd1 << 30), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
